// File: rtl/bram_line_refill_pkg.sv
// Shared constants and state encodings for the cache-line refill engine.
// Imported by the refill engine and available to its surrounding logic.
package bram_line_refill_pkg;

    localparam logic [1:0] BURST_WRAP = 2'b10;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    localparam int LINE_WORDS_DEF = 8;
    localparam int OFF_W_DEF      = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_FIN  = 2'd3
    } refill_state_e;

endpackage

// File: rtl/bram_line_refill.sv
// Cache-line refill engine: one wrapping AXI read burst, critical word first,
// each beat written into BRAM port 1, with early critical-word forwarding.
module bram_line_refill
    import bram_line_refill_pkg::*;
#(
    parameter int LINE_WORDS = LINE_WORDS_DEF,
    parameter int OFF_W      = OFF_W_DEF,
    parameter int ADDR_W     = 10
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_paddr,
    output logic              ar_valid,
    input  logic              ar_ready,
    output logic [31:0]       ar_addr,
    output logic [7:0]        ar_len,
    output logic [1:0]        ar_burst,
    input  logic              r_valid,
    output logic              r_ready,
    input  logic [31:0]       r_data,
    input  logic [1:0]        r_resp,
    input  logic              r_last,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [3:0]        bram_wen,
    output logic [31:0]       bram_wdata,
    output logic              crit_valid,
    output logic [31:0]       crit_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int LINE_W = ADDR_W - OFF_W;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

    refill_state_e     state_q, state_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [OFF_W-1:0]  start_q, start_d;
    logic [OFF_W-1:0]  cnt_q, cnt_d;
    logic              err_flag_q, err_flag_d;
    logic              resp_bad_q, resp_bad_d;
    logic [31:0]       ar_addr_q, ar_addr_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [3:0]        wen_q, wen_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              crit_valid_q, crit_valid_d;
    logic [31:0]       crit_data_q, crit_data_d;

    logic [OFF_W-1:0]  off_s;
    logic              beat_bad_s;
    logic              is_last_s;

    // Next-state, datapath capture and beat bookkeeping.
    always_comb begin
        state_d      = state_q;
        line_d       = line_q;
        start_d      = start_q;
        cnt_d        = cnt_q;
        err_flag_d   = err_flag_q;
        resp_bad_d   = resp_bad_q;
        ar_addr_d    = ar_addr_q;
        waddr_d      = waddr_q;
        wen_d        = 4'h0;
        wdata_d      = wdata_q;
        crit_valid_d = 1'b0;
        crit_data_d  = crit_data_q;
        off_s        = start_q + cnt_q;
        beat_bad_s   = (r_resp != RESP_OKAY);
        is_last_s    = (cnt_q == LAST_BEAT);

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    line_d    = req_addr[ADDR_W-1:OFF_W];
                    start_d   = req_addr[OFF_W-1:0];
                    ar_addr_d = {req_paddr[31:2], 2'b00};
                    cnt_d     = '0;
                    state_d   = ST_ADDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (ar_ready) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (r_valid) begin
                    waddr_d = {line_q, off_s};
                    wdata_d = r_data;
                    // An error beat poisons itself and every later beat of this line.
                    if (resp_bad_q || beat_bad_s) begin
                        wen_d = 4'h0;
                    end else begin
                        wen_d = 4'hF;
                    end
                    if ((cnt_q == '0) && !beat_bad_s) begin
                        crit_valid_d = 1'b1;
                        crit_data_d  = r_data;
                    end else begin
                        crit_valid_d = 1'b0;
                    end
                    if (beat_bad_s) begin
                        resp_bad_d = 1'b1;
                    end else begin
                        resp_bad_d = resp_bad_q;
                    end
                    if (beat_bad_s || (r_last != is_last_s)) begin
                        err_flag_d = 1'b1;
                    end else begin
                        err_flag_d = err_flag_q;
                    end
                    // Beat count, not r_last, decides when the line is complete.
                    if (is_last_s) begin
                        cnt_d   = '0;
                        state_d = ST_FIN;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_FIN: begin
                err_flag_d = 1'b0;
                resp_bad_d = 1'b0;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            line_q       <= '0;
            start_q      <= '0;
            cnt_q        <= '0;
            err_flag_q   <= 1'b0;
            resp_bad_q   <= 1'b0;
            ar_addr_q    <= 32'h0;
            waddr_q      <= '0;
            wen_q        <= 4'h0;
            wdata_q      <= 32'h0;
            crit_valid_q <= 1'b0;
            crit_data_q  <= 32'h0;
        end else begin
            state_q      <= state_d;
            line_q       <= line_d;
            start_q      <= start_d;
            cnt_q        <= cnt_d;
            err_flag_q   <= err_flag_d;
            resp_bad_q   <= resp_bad_d;
            ar_addr_q    <= ar_addr_d;
            waddr_q      <= waddr_d;
            wen_q        <= wen_d;
            wdata_q      <= wdata_d;
            crit_valid_q <= crit_valid_d;
            crit_data_q  <= crit_data_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign ar_valid   = (state_q == ST_ADDR);
    assign r_ready    = (state_q == ST_DATA);
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_FIN);
    assign err        = (state_q == ST_FIN) && err_flag_q;
    assign ar_addr    = ar_addr_q;
    assign ar_len     = 8'(LINE_WORDS - 1);
    assign ar_burst   = BURST_WRAP;
    assign bram_addr  = waddr_q;
    assign bram_wen   = wen_q;
    assign bram_wdata = wdata_q;
    assign crit_valid = crit_valid_q;
    assign crit_data  = crit_data_q;

endmodule
